dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port `data_memory` array between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA port. It arbitrates requests and presents a word-addressed access to memory. It also sequences sub-word stores as read-modify-write, because the memory only writes whole words. Loads are extracted and sign- or zero-extended before they are returned.

## Interface
- `ADDR_W`, 32: byte address width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pN_req`  in  1  request valid, N in {0,1}; must hold stable with its fields until granted.
- `pN_gnt`  out  1  request accepted this cycle; asserted only in IDLE.
- `pN_we`  in  1  1 = store, 0 = load.
- `pN_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `pN_unsigned`  in  1  load zero-extend when 1, sign-extend when 0.
- `pN_addr`  in  ADDR_W  byte address.
- `pN_wdata`  in  32  store data in the low bits.
- `pN_rsp_valid`  out  1  one-cycle response pulse to the requester that was granted.
- `pN_rsp_rdata`  out  32  extended load data, valid with `rsp_valid`; 0 for stores.
- `pN_rsp_err`  out  1  misaligned access or illegal size, valid with `rsp_valid`.
- `mem_read`  out  1  to `data_memory.mem_read`.
- `mem_write`  out  1  to `data_memory.mem_write`.
- `mem_addr`  out  32  word-aligned byte address; bits [1:0] always 0.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  combinational read data.

## Operation
- States:
  - IDLE: accept one request.
  - RMW: write the merged word.
  - RESP: drive the response pulse.
- IDLE, no request pending: no grant; all memory strobes 0.
- IDLE, request granted: latch port id, we, size, unsigned, addr and wdata; drive `mem_addr` = {addr[31:2], 2'b00}.
- Alignment check:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]≠0 is misaligned;
  - size 11 is illegal;
  - any of these: no strobe, go to RESP with err=1.
- Load: `mem_read`=1. Select the lane from addr[1:0], extend it and register it. Go to RESP.
- Word store: `mem_write`=1 with `mem_wdata`=wdata. Go to RESP.
- Byte or half store:
  - IDLE cycle: `mem_read`=1; register `mem_rdata`. Go to RMW.
  - RMW cycle: `mem_write`=1; the merged word replaces only the addressed byte or half. Go to RESP.
- RESP: the granted port gets `rsp_valid`=1 for one cycle. Next state is IDLE.
- Only one port is granted per cycle, and at most one transaction is in flight.
- Arbitration is fixed priority: port 0 wins ties.

## Timing
- A request is granted in cycle N only when the state is IDLE. `pN_gnt` is combinational from `pN_req` and the state.
- Response pulse, with N = grant cycle:
  - load, word store, or error: cycle N+1;
  - byte or half store: cycle N+2.
- Peak throughput is one access per 2 cycles; sub-word stores take 3 cycles.
- The response pulse is in the same cycle as `pN_gnt` for the next request? No. Grant is only possible in IDLE, so the earliest next grant is N+2.
- A port that is still requesting during its own RESP cycle is not granted until the following IDLE cycle.
- Reset:
  - state=IDLE;
  - all `gnt`, `rsp_valid`, `rsp_err`, `mem_read` and `mem_write` are 0;
  - `rsp_rdata`=0 and `mem_addr`=0;
  - round-robin pointer = port 1, so port 0 is favoured first.
- Reset during RMW abandons the write, leaving memory unchanged, and produces no response.
- Reset during RESP suppresses the pulse.

## Configuration
- `DMEM_ARB_RR_EN` defined: two-way round-robin.
  - The pointer records the last granted port. On a tie, the other port wins.
  - The pointer updates only on a grant.
- Undefined: fixed priority, port 0 always wins; no pointer state.

## Test plan
- Word store then load: p0 sw 0xDEADBEEF @0x10; p0 lw @0x10. Store pulse at N+1 with err=0; load returns 0xDEADBEEF one cycle after its grant.
- Sub-word store: word @0x20=0x11223344, then sb 0xAA @0x21. `mem_write` asserted exactly once, at N+1; `rsp_valid` at N+2; a later lw returns 0x1122AA44. Then lb @0x21 returns 0xFFFFFFAA and lbu returns 0x000000AA.
- Misaligned: lh @0x23 and lw @0x22. `mem_read`=`mem_write`=0 throughout; `rsp_err`=1 at N+1; memory unchanged.
- Contention, macro undefined: both ports request lw continuously. Port 0 is granted every 2 cycles and port 1 is never granted.
- Contention, `DMEM_ARB_RR_EN`: same stimulus. Grants alternate 0,1,0,1, with port 0 first after reset.
- Reset mid-RMW: assert `rst` in the RMW cycle of sb @0x21. No write occurs, no `rsp_valid`, state returns to IDLE, and a later lw @0x20 returns the old word.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word memory between the core LSU (port 0)
// and the debug/DMA port (port 1). Sub-word stores run as read-modify-write.
// Loads are lane-selected and sign/zero extended before they are returned.
// Optional feature macro: DMEM_ARB_RR_EN selects two-way round-robin
// arbitration. When it is undefined, port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    output logic              p0_gnt,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_unsigned,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req,
    output logic              p1_gnt,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic              p1_unsigned,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RMW  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    logic        port_r;
    logic [29:0] waddr_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] merged_r;

    logic        prefer_p1_s;
    logic        any_gnt_s;
    logic        sel_we_s;
    logic [1:0]  sel_size_s;
    logic        sel_uns_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_err_s;
    logic        rsp_active_s;

    // Misaligned half/word accesses and the reserved size encoding are errors.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
        logic e;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = lo[0];
            SZ_WORD: e = (lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: r = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte or half of the old word with store data.
    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] m;
        m = old;
        case (size)
            SZ_BYTE: m[{lo, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (lo[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            default: m = wd;
        endcase
        return m;
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic last_r;

    // Remember which port was granted last so a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (any_gnt_s) begin
            last_r <= p1_gnt;
        end else begin
            last_r <= last_r;
        end
    end

    assign prefer_p1_s = ~last_r;
`else
    assign prefer_p1_s = 1'b0;
`endif

    // Grant at most one port, and only while idle and out of reset.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (state == IDLE && !rst) begin
            if (p0_req && p1_req) begin
                if (prefer_p1_s) begin
                    p1_gnt = 1'b1;
                end else begin
                    p0_gnt = 1'b1;
                end
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end else begin
                p0_gnt = 1'b0;
            end
        end else begin
            p1_gnt = 1'b0;
        end
    end

    assign any_gnt_s   = p0_gnt | p1_gnt;
    assign sel_we_s    = p1_gnt ? p1_we       : p0_we;
    assign sel_size_s  = p1_gnt ? p1_size     : p0_size;
    assign sel_uns_s   = p1_gnt ? p1_unsigned : p0_unsigned;
    assign sel_addr_s  = p1_gnt ? 32'(p1_addr) : 32'(p0_addr);
    assign sel_wdata_s = p1_gnt ? p1_wdata    : p0_wdata;
    assign sel_err_s   = access_err(sel_size_s, sel_addr_s[1:0]);

    // Memory strobes: the first access happens in the grant cycle; RMW writes back.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (any_gnt_s) begin
                    mem_addr = {sel_addr_s[31:2], 2'b00};
                    if (sel_err_s) begin
                        mem_read = 1'b0;
                    end else if (sel_we_s && sel_size_s == SZ_WORD) begin
                        mem_write = 1'b1;
                        mem_wdata = sel_wdata_s;
                    end else begin
                        mem_read = 1'b1;
                    end
                end else begin
                    mem_read = 1'b0;
                end
            end
            RMW: begin
                mem_addr  = {waddr_r, 2'b00};
                mem_wdata = merged_r;
                if (!rst) begin
                    mem_write = 1'b1;
                end else begin
                    mem_write = 1'b0;
                end
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    // Transaction FSM: latch the granted request and register its results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            port_r   <= 1'b0;
            waddr_r  <= 30'h0;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            merged_r <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt_s) begin
                        port_r   <= p1_gnt;
                        waddr_r  <= sel_addr_s[31:2];
                        err_r    <= sel_err_s;
                        merged_r <= merge_word(mem_rdata, sel_wdata_s, sel_size_s, sel_addr_s[1:0]);
                        if (!sel_err_s && !sel_we_s) begin
                            rdata_r <= load_extend(mem_rdata, sel_size_s, sel_addr_s[1:0], sel_uns_s);
                        end else begin
                            rdata_r <= 32'h0000_0000;
                        end
                        if (!sel_err_s && sel_we_s && sel_size_s != SZ_WORD) begin
                            state <= RMW;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RMW:     state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_active_s = (state == RESP) && !rst;
    assign p0_rsp_valid = rsp_active_s && !port_r;
    assign p1_rsp_valid = rsp_active_s &&  port_r;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata_r : 32'h0000_0000;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata_r : 32'h0000_0000;
    assign p0_rsp_err   = p0_rsp_valid & err_r;
    assign p1_rsp_err   = p1_rsp_valid & err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_unsigned, p1_req, p1_we, p1_unsigned;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rsp_valid, p0_rsp_err, p1_gnt, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          w0, r0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    dmem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_we(p0_we), .p0_size(p0_size),
        .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_we(p1_we), .p1_size(p1_size),
        .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction from an idle arbiter; lat is 1 or 2 cycles grant-to-response.
    task automatic xact(input string tag, input int port, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input int lat);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_size = size; p0_unsigned = uns;
            p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_size = size; p1_unsigned = uns;
            p1_addr = addr; p1_wdata = wdata;
        end
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(port == 0 ? p0_gnt : p1_gnt), 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        if (lat == 2) begin
            @(negedge clk);
            chk({tag, "_rmw_wr"}, 32'(mem_write), 32'd1);
            chk({tag, "_rmw_novalid"}, 32'(port == 0 ? p0_rsp_valid : p1_rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_valid"}, 32'(port == 0 ? p0_rsp_valid : p1_rsp_valid), 32'd1);
        chk({tag, "_rdata"}, port == 0 ? p0_rsp_rdata : p1_rsp_rdata, exp_data);
        chk({tag, "_err"}, 32'(port == 0 ? p0_rsp_err : p1_rsp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_g0 [0:5];
        logic exp_g1 [0:5];
        logic exp_v0 [0:5];
        logic exp_v1 [0:5];
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_unsigned = 1'b0;
        p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_unsigned = 1'b0;
        p1_addr = 32'h0; p1_wdata = 32'h0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 32'(p0_gnt), 32'd0);
        chk("rst_valid", 32'({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", p0_rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_strobes", 32'({mem_read, mem_write, p0_gnt, p1_gnt}), 32'd0);
        @(posedge clk); #1;

        xact("sw10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        xact("lw10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        xact("sw20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1);
        w0 = wr_cnt;
        xact("sb21", 0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0, 2);
        chk("sb21_one_write", 32'(wr_cnt - w0), 32'd1);
        xact("lw20", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 1);
        xact("lb21", 0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0, 1);
        xact("lbu21", 0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0, 1);
        xact("lh22", 0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0, 1);

        r0 = rd_cnt; w0 = wr_cnt;
        xact("lh23", 0, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, 1);
        xact("lw22", 0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1);
        xact("sz11", 0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        chk("misal_no_read", 32'(rd_cnt - r0), 32'd0);
        chk("misal_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("misal_mem", mem[8], 32'h1122AA44);

        xact("p1_sh12", 1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0, 1'b0, 2);
        xact("p1_lhu12", 1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008001, 1'b0, 1);
        xact("p1_lh12", 1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 1);
        xact("p0_lw10b", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8001BEEF, 1'b0, 1);

        // Reset in the RMW cycle of sb 0x55 @0x21.
        w0 = wr_cnt;
        p0_req = 1'b1; p0_we = 1'b1; p0_size = 2'b00; p0_unsigned = 1'b0;
        p0_addr = 32'h21; p0_wdata = 32'h00000055;
        @(negedge clk);
        chk("rmwrst_gnt", 32'(p0_gnt), 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rmwrst_nowrite", 32'(mem_write), 32'd0);
        chk("rmwrst_novalid", 32'(p0_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmwrst_novalid2", 32'(p0_rsp_valid), 32'd0);
        chk("rmwrst_wcount", 32'(wr_cnt - w0), 32'd0);
        @(posedge clk); #1;
        xact("rmwrst_lw20", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 1);

        // Contention straight after reset: both ports load continuously.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_g0 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_g1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_v0 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_v1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v0 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_v1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        p0_req = 1'b1; p0_we = 1'b0; p0_size = 2'b10; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_size = 2'b10; p1_addr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("cont_g0_%0d", i), 32'(p0_gnt), 32'(exp_g0[i]));
            chk($sformatf("cont_g1_%0d", i), 32'(p1_gnt), 32'(exp_g1[i]));
            chk($sformatf("cont_v0_%0d", i), 32'(p0_rsp_valid), 32'(exp_v0[i]));
            chk($sformatf("cont_v1_%0d", i), 32'(p1_rsp_valid), 32'(exp_v1[i]));
            @(posedge clk); #1;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
